// File: rtl/spi_slave_mode.sv
// SPI slave supporting all four CPOL/CPHA modes, configurable word width and
// bit order, multi-word frames, and a one-word transmit holding buffer.
// SCK, CS and MOSI are oversampled in the i_clk domain.
module spi_slave_mode #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_tx_underrun,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_end,
    output logic              o_frame_err,
    output logic              o_busy,
    input  logic              i_spi_cs,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic             SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_r, cs_sync_r, mosi_sync_r;
    logic                   sck_d_r, cs_d_r, mosi_smp_r;
    logic                   lead_r, trail_r, cs_fall_r, cs_rise_r;
    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       bit_cnt_r, cnt_smp_s;
    logic [DATA_W-1:0]      tx_sr_r, rx_sr_r, hold_r, rx_data_r, rx_next_s;
    logic                   full_r, tx_ready_r, underrun_r, rx_valid_r;
    logic                   frame_end_r, frame_err_r, busy_r;
    logic                   active_s, sample_s, shift_s, load_s, word_done_s;
    logic                   accept_s, full_next_s, miso_bit_s;
    logic                   frame_end_s, frame_err_s, busy_s;

    // Synchronise the raw SPI pins into the i_clk domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_r  <= {SYNC_STAGES{SCK_IDLE}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], i_spi_clk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_spi_cs};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end

    // Registered edge flags; MOSI is delayed alongside so it lines up with them
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_d_r    <= SCK_IDLE;
            cs_d_r     <= 1'b1;
            mosi_smp_r <= 1'b0;
            lead_r     <= 1'b0;
            trail_r    <= 1'b0;
            cs_fall_r  <= 1'b0;
            cs_rise_r  <= 1'b0;
        end else begin
            sck_d_r    <= sck_sync_r[SYNC_STAGES-1];
            cs_d_r     <= cs_sync_r[SYNC_STAGES-1];
            mosi_smp_r <= mosi_sync_r[SYNC_STAGES-1];
            lead_r     <= (sck_sync_r[SYNC_STAGES-1] != SCK_IDLE) && (sck_d_r == SCK_IDLE);
            trail_r    <= (sck_sync_r[SYNC_STAGES-1] == SCK_IDLE) && (sck_d_r != SCK_IDLE);
            cs_fall_r  <= !cs_sync_r[SYNC_STAGES-1] && cs_d_r;
            cs_rise_r  <= cs_sync_r[SYNC_STAGES-1] && !cs_d_r;
        end
    end

    // Decode sample / shift / load events and the post-sample bit count
    always_comb begin
        active_s = (state_r == ST_ACTIVE);
        if (CPHA == 0) begin
            sample_s = active_s && lead_r;
            shift_s  = active_s && trail_r;
            load_s   = (!active_s && cs_fall_r) || (shift_s && (bit_cnt_r == CNT_ZERO));
        end else begin
            sample_s = active_s && trail_r;
            shift_s  = active_s && lead_r;
            load_s   = shift_s && (bit_cnt_r == CNT_ZERO);
        end
        word_done_s = sample_s && (bit_cnt_r == CNT_LAST);
        if (!sample_s) begin
            cnt_smp_s = bit_cnt_r;
        end else if (word_done_s) begin
            cnt_smp_s = CNT_ZERO;
        end else begin
            cnt_smp_s = bit_cnt_r + CNT_ONE;
        end
        if (MSB_FIRST != 0) begin
            rx_next_s  = {rx_sr_r[DATA_W-2:0], mosi_smp_r};
            miso_bit_s = tx_sr_r[DATA_W-1];
        end else begin
            rx_next_s  = {mosi_smp_r, rx_sr_r[DATA_W-1:1]};
            miso_bit_s = tx_sr_r[0];
        end
        accept_s = i_tx_valid && tx_ready_r;
        if (load_s) begin
            full_next_s = 1'b0;
        end else if (accept_s) begin
            full_next_s = 1'b1;
        end else begin
            full_next_s = full_r;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic: CS fall opens a frame, CS rise closes it
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = cs_fall_r ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_s = cs_rise_r ? ST_IDLE : ST_ACTIVE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM outputs; a coincident final sample is counted before the frame closes
    always_comb begin
        frame_end_s = 1'b0;
        frame_err_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = (state_s == ST_ACTIVE);
            end
            ST_ACTIVE: begin
                frame_end_s = cs_rise_r;
                frame_err_s = cs_rise_r && (cnt_smp_s != CNT_ZERO);
                busy_s      = (state_s == ST_ACTIVE);
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Bit counter, receive shifter and transmit shifter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt_r <= CNT_ZERO;
            rx_sr_r   <= WORD_ZERO;
            tx_sr_r   <= WORD_ZERO;
        end else begin
            bit_cnt_r <= frame_end_s ? CNT_ZERO : cnt_smp_s;
            if (frame_end_s) begin
                rx_sr_r <= WORD_ZERO;
            end else if (sample_s) begin
                rx_sr_r <= rx_next_s;
            end
            if (load_s) begin
                if (full_r) begin
                    tx_sr_r <= hold_r;
                end else if (accept_s) begin
                    tx_sr_r <= i_tx_data;
                end else begin
                    tx_sr_r <= WORD_ZERO;
                end
            end else if (shift_s) begin
                if (MSB_FIRST != 0) begin
                    tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
                end else begin
                    tx_sr_r <= {1'b0, tx_sr_r[DATA_W-1:1]};
                end
            end
        end
    end

    // Transmit holding buffer and handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_r     <= WORD_ZERO;
            full_r     <= 1'b0;
            tx_ready_r <= 1'b0;
        end else begin
            if (accept_s && !load_s) begin
                hold_r <= i_tx_data;
            end
            full_r     <= full_next_s;
            tx_ready_r <= !full_next_s;
        end
    end

    // Registered status pulses and received word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_data_r   <= WORD_ZERO;
            rx_valid_r  <= 1'b0;
            underrun_r  <= 1'b0;
            frame_end_r <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (word_done_s) begin
                rx_data_r <= rx_next_s;
            end
            rx_valid_r  <= word_done_s;
            underrun_r  <= load_s && !full_r && !accept_s;
            frame_end_r <= frame_end_s;
            frame_err_r <= frame_err_s;
            busy_r      <= busy_s;
        end
    end

    assign o_tx_ready    = tx_ready_r;
    assign o_tx_underrun = underrun_r;
    assign o_rx_data     = rx_data_r;
    assign o_rx_valid    = rx_valid_r;
    assign o_frame_end   = frame_end_r;
    assign o_frame_err   = frame_err_r;
    assign o_busy        = busy_r;
    assign o_spi_miso    = i_spi_cs ? 1'bz : miso_bit_s;
endmodule

// File: tb/tb_spi_slave_mode.sv
// Scoreboard bench for spi_slave_mode: four instances cover modes 0, 1, 3
// (8-bit MSB first) and mode 2 (16-bit LSB first), sharing SCK/MOSI.
module tb_spi_slave_mode;
    localparam int HP = 10;

    typedef struct {
        int          dut;
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic        clk, rst_n, sck, mosi;
    logic [3:0]  cs, tx_valid, tx_ready, underrun, rx_valid, frame_end, frame_err, busy;
    logic [15:0] tx_data;
    logic [7:0]  rxd0, rxd1, rxd2;
    logic [15:0] rxd3;
    wire         miso0, miso1, miso2, miso3;
    logic [15:0] mi_a, mi_b;
    int          checks, errors;
    int          und_cnt [4];
    ev_t         exp_q [$];

    spi_slave_mode #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[7:0]), .i_tx_valid(tx_valid[0]),
        .o_tx_ready(tx_ready[0]), .o_tx_underrun(underrun[0]), .o_rx_data(rxd0),
        .o_rx_valid(rx_valid[0]), .o_frame_end(frame_end[0]), .o_frame_err(frame_err[0]),
        .o_busy(busy[0]), .i_spi_cs(cs[0]), .i_spi_clk(sck), .i_spi_mosi(mosi), .o_spi_miso(miso0));
    spi_slave_mode #(.DATA_W(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[7:0]), .i_tx_valid(tx_valid[1]),
        .o_tx_ready(tx_ready[1]), .o_tx_underrun(underrun[1]), .o_rx_data(rxd1),
        .o_rx_valid(rx_valid[1]), .o_frame_end(frame_end[1]), .o_frame_err(frame_err[1]),
        .o_busy(busy[1]), .i_spi_cs(cs[1]), .i_spi_clk(sck), .i_spi_mosi(mosi), .o_spi_miso(miso1));
    spi_slave_mode #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[7:0]), .i_tx_valid(tx_valid[2]),
        .o_tx_ready(tx_ready[2]), .o_tx_underrun(underrun[2]), .o_rx_data(rxd2),
        .o_rx_valid(rx_valid[2]), .o_frame_end(frame_end[2]), .o_frame_err(frame_err[2]),
        .o_busy(busy[2]), .i_spi_cs(cs[2]), .i_spi_clk(sck), .i_spi_mosi(mosi), .o_spi_miso(miso2));
    spi_slave_mode #(.DATA_W(16), .CPOL(1), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_m2w16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid[3]),
        .o_tx_ready(tx_ready[3]), .o_tx_underrun(underrun[3]), .o_rx_data(rxd3),
        .o_rx_valid(rx_valid[3]), .o_frame_end(frame_end[3]), .o_frame_err(frame_err[3]),
        .o_busy(busy[3]), .i_spi_cs(cs[3]), .i_spi_clk(sck), .i_spi_mosi(mosi), .o_spi_miso(miso3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic miso_of(input int d);
        case (d)
            0:       return miso0;
            1:       return miso1;
            2:       return miso2;
            default: return miso3;
        endcase
    endfunction

    function automatic logic [15:0] rxd_of(input int d);
        case (d)
            0:       return {8'h00, rxd0};
            1:       return {8'h00, rxd1};
            2:       return {8'h00, rxd2};
            default: return rxd3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int d, input int kind, input logic [15:0] val);
        ev_t e;
        e.dut  = d;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int d, input int kind, input logic [15:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected dut=%0d kind=%0d actual=%h expected=none", d, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL sb_event actual=dut%0d/kind%0d/%h expected=dut%0d/kind%0d/%h",
                         d, kind, val, e.dut, e.kind, e.val);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a word or a frame end
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i]) sb_check(i, 0, rxd_of(i));
            if (frame_end[i]) sb_check(i, 1, {15'd0, frame_err[i]});
            if (frame_err[i] && !frame_end[i]) chk("err_without_end", 32'd1, 32'd0);
            if (underrun[i]) und_cnt[i]++;
        end
    end

    task automatic hp();
        repeat (HP) @(negedge clk);
    endtask

    task automatic push_tx(input int d, input logic [15:0] val);
        int n;
        n = 0;
        tx_data     = val;
        tx_valid[d] = 1'b1;
        while (!tx_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("tx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid[d] = 1'b0;
    endtask

    task automatic cs_begin(input int d, input int cpol);
        sck = (cpol != 0) ? 1'b1 : 1'b0;
        hp();
        cs[d] = 1'b0;
        hp();
        chk("busy_in_frame", {31'd0, busy[d]}, 32'd1);
    endtask

    task automatic cs_end(input int d);
        hp();
        cs[d] = 1'b1;
        hp();
        hp();
        chk("busy_after_frame", {31'd0, busy[d]}, 32'd0);
    endtask

    task automatic xfer(input int d, input int cpol, input int cpha, input int msb, input int w,
                        input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        int   pos;
        logic idle_lvl;
        idle_lvl = (cpol != 0) ? 1'b1 : 1'b0;
        mi = 16'h0000;
        for (int k = 0; k < nbits; k++) begin
            pos = (msb != 0) ? (w - 1 - k) : k;
            if (cpha == 0) begin
                mosi = mo[pos];
                hp();
                mi[pos] = miso_of(d);
                sck = ~idle_lvl;
                hp();
                sck = idle_lvl;
            end else begin
                sck  = ~idle_lvl;
                mosi = mo[pos];
                hp();
                mi[pos] = miso_of(d);
                sck = idle_lvl;
                hp();
            end
        end
    endtask

    task automatic clear_und();
        for (int i = 0; i < 4; i++) und_cnt[i] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs = 4'hF; tx_valid = 4'h0; tx_data = 16'h0000;
        clear_und();
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {28'd0, tx_ready}, 32'h0);
        chk("rst_pulses", {16'd0, rx_valid, frame_end, frame_err, underrun}, 32'h0);
        chk("rst_rx_data", {16'd0, rxd3}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {28'd0, tx_ready}, 32'hF);

        // Mode 0, buffer preloaded with 0x3C, MOSI 0xA5
        push_tx(0, 16'h003C);
        clear_und();
        expect_ev(0, 0, 16'h00A5);
        expect_ev(0, 1, 16'h0000);
        cs_begin(0, 0);
        xfer(0, 0, 0, 1, 8, 8, 16'h00A5, mi_a);
        cs_end(0);
        chk("m0_miso", {16'd0, mi_a}, 32'h3C);
        chk("m0_rx_data", {16'd0, rxd_of(0)}, 32'hA5);
        chk("m0_underrun", und_cnt[0], 32'd1);

        // Mode 3 two-word frame, second tx word supplied during the first
        push_tx(2, 16'h0012);
        clear_und();
        expect_ev(2, 0, 16'h00C3);
        expect_ev(2, 0, 16'h005A);
        expect_ev(2, 1, 16'h0000);
        cs_begin(2, 1);
        fork
            begin
                xfer(2, 1, 1, 1, 8, 8, 16'h00C3, mi_a);
                xfer(2, 1, 1, 1, 8, 8, 16'h005A, mi_b);
            end
            begin
                repeat (3 * HP) @(negedge clk);
                push_tx(2, 16'h0034);
            end
        join
        cs_end(2);
        chk("m3_miso_w0", {16'd0, mi_a}, 32'h12);
        chk("m3_miso_w1", {16'd0, mi_b}, 32'h34);
        chk("m3_underrun", und_cnt[2], 32'd0);

        // Mode 1, empty buffer: zeros out, one underrun
        clear_und();
        expect_ev(1, 0, 16'h00FF);
        expect_ev(1, 1, 16'h0000);
        cs_begin(1, 0);
        xfer(1, 0, 1, 1, 8, 8, 16'h00FF, mi_a);
        cs_end(1);
        chk("m1_miso", {16'd0, mi_a}, 32'h00);
        chk("m1_underrun", und_cnt[1], 32'd1);
        chk("m1_rx_data", {16'd0, rxd_of(1)}, 32'hFF);

        // Mode 0 partial frame of 5 bits
        clear_und();
        expect_ev(0, 1, 16'h0001);
        cs_begin(0, 0);
        xfer(0, 0, 0, 1, 8, 5, 16'h0055, mi_a);
        cs_end(0);
        chk("partial_rx_hold", {16'd0, rxd_of(0)}, 32'hA5);
        chk("partial_underrun", und_cnt[0], 32'd1);

        // 16-bit LSB-first mode 2
        push_tx(3, 16'hBEEF);
        clear_und();
        expect_ev(3, 0, 16'h1234);
        expect_ev(3, 1, 16'h0000);
        cs_begin(3, 1);
        xfer(3, 1, 0, 0, 16, 16, 16'h1234, mi_a);
        cs_end(3);
        chk("w16_miso", {16'd0, mi_a}, 32'hBEEF);
        chk("w16_rx_data", {16'd0, rxd_of(3)}, 32'h1234);
        chk("w16_underrun", und_cnt[3], 32'd1);

        // Reset mid-word in mode 0, then a clean frame 0x81
        cs_begin(0, 0);
        xfer(0, 0, 0, 1, 8, 4, 16'h00F0, mi_a);
        @(negedge clk);
        rst_n = 1'b0;
        cs[0] = 1'b1;
        sck   = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {22'd0, tx_ready[0], underrun[0], rx_valid[0], frame_end[0],
                               frame_err[0], busy[0], 2'b00}, 32'h0);
        chk("midrst_rx_data", {16'd0, rxd_of(0)}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, tx_ready[0]}, 32'd1);
        push_tx(0, 16'h005A);
        clear_und();
        expect_ev(0, 0, 16'h0081);
        expect_ev(0, 1, 16'h0000);
        cs_begin(0, 0);
        xfer(0, 0, 0, 1, 8, 8, 16'h0081, mi_a);
        cs_end(0);
        chk("postrst_miso", {16'd0, mi_a}, 32'h5A);
        chk("postrst_rx_data", {16'd0, rxd_of(0)}, 32'h81);
        chk("postrst_underrun", und_cnt[0], 32'd1);

        repeat (20) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_mode.md
Name: spi_slave_mode

Overview:
Parametrised SPI slave for the serial-peripheral chapter designs. It supports all four CPOL/CPHA modes, configurable word width and bit order, and multi-word frames under one chip-select. Transmit words are supplied through a one-word valid/ready holding buffer. Each received word is reported with a single-cycle valid pulse. All SPI pins are oversampled in the i_clk domain.

Parameters:
DATA_W, 8, bits per SPI word (2..32)
CPOL, 0, SCK idle level; leading edge = transition away from CPOL
CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading edge, sample on trailing
MSB_FIRST, 1, 1: bit DATA_W-1 goes first; 0: bit 0 goes first
SYNC_STAGES, 2, synchroniser flops on i_spi_clk, i_spi_cs, i_spi_mosi (>=2)

Ports:
i_clk  in  1  system clock; must be at least 2*(SYNC_STAGES+2) times the SCK frequency
i_rst_n  in  1  reset, asynchronous, active-low
i_tx_data  in  DATA_W  next word to transmit
i_tx_valid  in  1  i_tx_data valid
o_tx_ready  out  1  holding buffer empty; a word is accepted when valid&ready
o_tx_underrun  out  1  1-cycle pulse: a word was loaded for shifting while the buffer was empty (zeros sent)
o_rx_data  out  DATA_W  last complete received word; held until the next word completes
o_rx_valid  out  1  1-cycle pulse: o_rx_data updated
o_frame_end  out  1  1-cycle pulse on synchronised CS rising edge
o_frame_err  out  1  1-cycle pulse with o_frame_end if the bit count is not 0 (partial word discarded)
o_busy  out  1  FSM in ACTIVE
i_spi_cs  in  1  chip select, active low
i_spi_clk  in  1  SCK
i_spi_mosi  in  1  master-out data
o_spi_miso  out  1  shift-register output bit while raw i_spi_cs==0, else 1'bz (combinational on raw pin)

Behaviour:
- Reset: all outputs 0 (o_spi_miso follows the CS rule); holding buffer empty, so o_tx_ready=1 one cycle after reset release; FSM=IDLE; bit counter 0; shift registers 0; synchroniser flops load CPOL for SCK, 1 for CS, 0 for MOSI.
- Edge detection: registered edge flags taken from the last synchroniser stage versus one delay flop. The leading/trailing mapping follows CPOL.
- Holding buffer: one word plus a full flag. Handshake acceptance sets full. A word-load event clears it. A same-cycle accept and load passes the new word straight through and leaves the buffer empty.
- Word-load event: in CPHA=0, on CS fall and on the trailing edge after the DATA_W-th sample. In CPHA=1, on the leading edge when the bit counter is 0. If the buffer is empty, load zeros and pulse o_tx_underrun.
- Shift event: on a non-load shift edge, move the tx register one bit toward the output end (output end set by MSB_FIRST).
- Sample: on each sample edge in ACTIVE, shift MOSI into the rx register and increment the bit counter. When the count reaches DATA_W: wrap to 0, set o_rx_data to the assembled word (bit order per MSB_FIRST), and pulse o_rx_valid in the next cycle.
- Latency: o_rx_valid rises SYNC_STAGES+2 i_clk cycles after the final sampling SCK edge at the pin.
- FSM: IDLE -> ACTIVE on synchronised CS fall (CPHA=0 load happens here). ACTIVE -> IDLE on synchronised CS rise, pulsing o_frame_end, plus o_frame_err if the count is not 0. In that case the count clears and the partial rx word is dropped with no o_rx_valid.
- SCK edges in IDLE are ignored.
- A CS rise coinciding with a sample edge: the sample is processed first, then the frame ends.
- Reset asserted mid-frame: immediate return to reset state; no pulses until a fresh CS fall is seen after release.
- The holding buffer keeps an accepted word across frames; underrun is reported only at load events.

Test Plan:
- Mode 0, DATA_W=8, buffer preloaded with 0x3C, master sends 0xA5 in one 8-bit frame -> MISO bits 0,0,1,1,1,1,0,0; one o_rx_valid with o_rx_data=0xA5; o_frame_end pulse; o_frame_err=0.
- Mode 3, two-word frame, tx 0x12 then 0x34 (the second supplied while the first shifts), MOSI 0xC3,0x5A -> MISO 0x12,0x34; two o_rx_valid pulses with 0xC3 then 0x5A; no underrun.
- Mode 1, buffer empty at frame start, MOSI 0xFF -> MISO all 0; o_tx_underrun pulses once; o_rx_data=0xFF.
- Mode 0, CS raised after 5 SCK cycles -> o_frame_end and o_frame_err pulse together; no o_rx_valid; o_rx_data keeps its previous value.
- DATA_W=16, MSB_FIRST=0, mode 2, tx 0xBEEF, MOSI 0x1234 LSB first -> MISO carries 0xBEEF LSB first; o_rx_data=0x1234.
- i_rst_n pulsed low mid-word in mode 0 -> outputs 0, o_tx_ready=1 after release; the next full frame 0x81 is received correctly.
